// File: rtl/gather_rt_lookup_arbiter_pkg.sv
// Shared sizing and types for the gather route-table lookup arbiter.
// Table depth and candidate-VC width follow ROUTE_TABLE_DEPTH / CN when the build defines them.
`ifndef ROUTE_TABLE_DEPTH
`define ROUTE_TABLE_DEPTH 32
`endif
`ifndef CN
`define CN 4
`endif

package gather_rt_pkg;
  localparam int RT_IDW   = 10;
  localparam int RT_NPORT = 5;
  localparam int RT_DEPTH = `ROUTE_TABLE_DEPTH;
  localparam int RT_CN    = `CN;

  typedef struct packed {
    logic              valid;
    logic [RT_CN-1:0]  vc;
    logic [RT_IDW-1:0] id;
  } rt_entry_t;

  typedef enum logic [1:0] {IDLE, SCAN, RESP} fsm_t;
endpackage

// File: rtl/gather_rt_lookup_arbiter_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or after the pointer.
// The pointer moves past the winner only when a grant is actually issued.
module rr_arbiter #(
  parameter int N  = 5,
  parameter int PW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  input  logic          en,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] gnt_idx
);
  logic [PW-1:0] ptr_q, ptr_d;
  int            p;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    ptr_d   = ptr_q;
    p       = 0;
    // Walk offsets from the far end so the nearest requester is written last.
    for (int i = N - 1; i >= 0; i--) begin
      p = int'(ptr_q) + i;
      if (p >= N) p = p - N;
      if (en && req[p]) begin
        gnt      = '0;
        gnt[p]   = 1'b1;
        gnt_idx  = PW'(p);
        ptr_d    = (p == N - 1) ? '0 : PW'(p + 1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end
endmodule

// File: rtl/gather_rt_lookup_arbiter.sv
// Multi-port gather route-table lookup: RR grant, linear scan FSM, runtime table writes.
// Optional last-hit cache enabled by GATHER_RT_LAST_HIT_CACHE_EN.
module gather_rt_lookup_arbiter
  import gather_rt_pkg::*;
#(
  parameter int NPORT = RT_NPORT,
  parameter int DEPTH = RT_DEPTH,
  parameter int CN    = RT_CN,
  parameter int IDW   = RT_IDW
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NPORT-1:0]         req_valid,
  input  logic [NPORT*IDW-1:0]     req_stream_id,
  output logic [NPORT-1:0]         req_ready,
  output logic                     resp_valid,
  output logic [$clog2(NPORT)-1:0] resp_port,
  output logic [CN-1:0]            resp_vc,
  output logic                     resp_miss,
  input  logic                     resp_ready,
  input  logic                     cfg_we,
  input  logic [$clog2(DEPTH)-1:0] cfg_addr,
  input  logic                     cfg_entry_valid,
  input  logic [IDW-1:0]           cfg_id,
  input  logic [CN-1:0]            cfg_vc,
  output logic                     cfg_ready
);
  localparam int PW = $clog2(NPORT);
  localparam int AW = $clog2(DEPTH);

  fsm_t          state_q, state_d;
  rt_entry_t     tbl_q [DEPTH];
  rt_entry_t     tbl_d [DEPTH];
  logic [AW-1:0] idx_q, idx_d;
  logic [IDW-1:0] id_q, id_d;
  logic [PW-1:0] port_q, port_d;
  logic [CN-1:0] vc_q, vc_d;
  logic          miss_q, miss_d;

  logic [NPORT-1:0] gnt;
  logic [PW-1:0]    gnt_idx;
  logic             arb_en, tbl_we, hit, cache_hit;
  logic [CN-1:0]    cache_vc;
  rt_entry_t        cur;

  // Writes own the IDLE cycle; a grant is only offered when no write is pending.
  assign tbl_we = (state_q == IDLE) && cfg_we;
  assign arb_en = (state_q == IDLE) && !cfg_we && !rst;
  assign cur    = tbl_q[idx_q];
  assign hit    = cur.valid && (cur.id == id_q);

  rr_arbiter #(.N(NPORT), .PW(PW)) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (req_valid),
    .en      (arb_en),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

`ifdef GATHER_RT_LAST_HIT_CACHE_EN
  rt_entry_t cache_q, cache_d;

  // Checked on the first scan cycle so the grant path stays free of the compare.
  assign cache_hit = cache_q.valid && (cache_q.id == id_q) && (idx_q == '0);
  assign cache_vc  = cache_q.vc;

  always_comb begin
    cache_d = cache_q;
    if (tbl_we) cache_d.valid = 1'b0;
    else if ((state_q == SCAN) && hit && !cache_hit)
      cache_d = '{valid: 1'b1, vc: cur.vc, id: id_q};
  end

  always_ff @(posedge clk) begin
    if (rst) cache_q <= '0;
    else     cache_q <= cache_d;
  end
`else
  assign cache_hit = 1'b0;
  assign cache_vc  = '0;
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    id_d    = id_q;
    port_d  = port_q;
    vc_d    = vc_q;
    miss_d  = miss_q;
    tbl_d   = tbl_q;
    if (tbl_we) tbl_d[cfg_addr] = '{valid: cfg_entry_valid, vc: cfg_vc, id: cfg_id};
    case (state_q)
      IDLE: if (|gnt) begin
        id_d    = req_stream_id[gnt_idx*IDW +: IDW];
        port_d  = gnt_idx;
        idx_d   = '0;
        state_d = SCAN;
      end
      SCAN: begin
        if (cache_hit) begin
          vc_d    = cache_vc;
          miss_d  = 1'b0;
          state_d = RESP;
        end else if (hit) begin
          vc_d    = cur.vc;
          miss_d  = 1'b0;
          state_d = RESP;
        end else if (idx_q == AW'(DEPTH - 1)) begin
          vc_d    = '0;
          miss_d  = 1'b1;
          state_d = RESP;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      RESP:    if (resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      id_q    <= '0;
      port_q  <= '0;
      vc_q    <= '0;
      miss_q  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) tbl_q[i].valid <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      id_q    <= id_d;
      port_q  <= port_d;
      vc_q    <= vc_d;
      miss_q  <= miss_d;
      tbl_q   <= tbl_d;
    end
  end

  assign req_ready  = gnt;
  assign resp_valid = (state_q == RESP);
  assign resp_port  = port_q;
  assign resp_vc    = vc_q;
  assign resp_miss  = miss_q;
  assign cfg_ready  = (state_q == IDLE);
endmodule

// File: tb/tb_gather_rt_lookup_arbiter.sv
// Scoreboard bench for gather_rt_lookup_arbiter: a monitor predicts grants, table state and
// response latency from the lookup rules; the driver mixes directed cases with random traffic.
module tb_gather_rt_lookup_arbiter;
  localparam int NPORT = 5, DEPTH = 32, CN = 4, IDW = 10;

  logic                 clk = 1'b0, rst = 1'b1;
  logic [NPORT-1:0]     req_valid = '0;
  logic [NPORT*IDW-1:0] req_stream_id = '0;
  logic [NPORT-1:0]     req_ready;
  logic                 resp_valid, resp_miss, cfg_ready;
  logic [2:0]           resp_port;
  logic [CN-1:0]        resp_vc;
  logic                 resp_ready = 1'b1;
  logic                 cfg_we = 1'b0, cfg_entry_valid = 1'b0;
  logic [4:0]           cfg_addr = '0;
  logic [IDW-1:0]       cfg_id = '0;
  logic [CN-1:0]        cfg_vc = '0;

  always #5 clk = ~clk;

  gather_rt_lookup_arbiter dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_stream_id(req_stream_id),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_port(resp_port), .resp_vc(resp_vc),
    .resp_miss(resp_miss), .resp_ready(resp_ready), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_entry_valid(cfg_entry_valid), .cfg_id(cfg_id), .cfg_vc(cfg_vc), .cfg_ready(cfg_ready)
  );

  typedef struct {int port; int vc; int miss; int due;} exp_t;

  int n_cmp = 0, n_bad = 0, cyc = 0;
  exp_t q[$];
  bit front_seen = 0, busy = 0;
  int ptr = 0;
  bit m_v[DEPTH];
  int m_id[DEPTH], m_vc[DEPTH];
  bit c_v = 0;
  int c_id = 0, c_vc = 0;
  logic [NPORT-1:0] gmask = '0;
  bit cfg_acc = 0;
  int mon_g, mon_expm;
  exp_t mon_e;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Lowest valid matching entry wins; latency counts grant edge to RESP entry.
  function automatic exp_t lookup(input int port, input int id);
    exp_t e;
    e.port = port; e.vc = 0; e.miss = 1; e.due = DEPTH;
`ifdef GATHER_RT_LAST_HIT_CACHE_EN
    if (c_v && c_id == id) begin
      e.vc = c_vc; e.miss = 0; e.due = 1;
      return e;
    end
`endif
    for (int k = 0; k < DEPTH; k++)
      if (m_v[k] && m_id[k] == id) begin
        e.vc = m_vc[k]; e.miss = 0; e.due = k + 1;
        c_v = 1; c_id = id; c_vc = m_vc[k];
        return e;
      end
    return e;
  endfunction

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      q.delete(); front_seen = 0; busy = 0; ptr = 0; c_v = 0; gmask = '0; cfg_acc = 0;
      for (int k = 0; k < DEPTH; k++) m_v[k] = 0;
    end else begin
      if (cfg_we) begin
        chk("cfg_ready", 32'(cfg_ready), 32'(!busy));
        if (!busy) begin
          m_v[cfg_addr] = cfg_entry_valid; m_id[cfg_addr] = int'(cfg_id);
          m_vc[cfg_addr] = int'(cfg_vc); c_v = 0; cfg_acc = 1;
        end
      end
      mon_g = -1;
      if (!busy && !cfg_we)
        for (int i = 0; i < NPORT; i++)
          if (mon_g < 0 && req_valid[(ptr + i) % NPORT]) mon_g = (ptr + i) % NPORT;
      mon_expm = (mon_g >= 0) ? (1 << mon_g) : 0;
      if (req_ready != '0 || mon_expm != 0) chk("grant", 32'(req_ready), 32'(mon_expm));
      gmask = req_ready;
      if (mon_g >= 0) begin
        ptr = (mon_g + 1) % NPORT;
        mon_e = lookup(mon_g, int'(req_stream_id[mon_g*IDW +: IDW]));
        mon_e.due = cyc + 1 + mon_e.due;
        q.push_back(mon_e);
        busy = 1;
      end
      if (q.size() != 0 && !front_seen && cyc == q[0].due) begin
        chk("latency", 32'(resp_valid), 32'd1);
        front_seen = 1;
      end else if (resp_valid && (q.size() == 0 || !front_seen)) begin
        chk("unexpected_resp", 32'(resp_valid), 32'd0);
      end
      if (resp_valid && q.size() != 0 && front_seen) begin
        chk("resp_port", 32'(resp_port), 32'(q[0].port));
        chk("resp_vc",   32'(resp_vc),   32'(q[0].vc));
        chk("resp_miss", 32'(resp_miss), 32'(q[0].miss));
        if (resp_ready) begin
          void'(q.pop_front()); front_seen = 0; busy = 0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
    if (cfg_acc) begin cfg_we = 1'b0; cfg_acc = 0; end
    req_valid = req_valid & ~gmask;
    gmask = '0;
  endtask

  task automatic set_cfg(input int a, input bit v, input int id, input int vc);
    cfg_addr = 5'(a); cfg_entry_valid = v; cfg_id = IDW'(id); cfg_vc = CN'(vc); cfg_we = 1'b1;
  endtask

  task automatic wr(input int a, input bit v, input int id, input int vc);
    int n = 0;
    set_cfg(a, v, id, vc);
    while (cfg_we && n < 200) begin tick(); n++; end
    if (n >= 200) chk("write_timeout", 32'(cfg_we), 32'd0);
  endtask

  task automatic req(input int p, input int id);
    req_stream_id[p*IDW +: IDW] = IDW'(id);
    req_valid[p] = 1'b1;
  endtask

  task automatic wait_done();
    int n = 0;
    while ((req_valid != '0 || busy || q.size() != 0 || cfg_we) && n < 2000) begin tick(); n++; end
    if (n >= 2000) chk("drain_timeout", 32'(q.size()), 32'd0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_ready"},  32'(req_ready),  32'd0);
    chk({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
    chk({tag, "_resp_port"},  32'(resp_port),  32'd0);
    chk({tag, "_resp_vc"},    32'(resp_vc),    32'd0);
    chk({tag, "_resp_miss"},  32'(resp_miss),  32'd0);
    chk({tag, "_cfg_ready"},  32'(cfg_ready),  32'd1);
  endtask

  function automatic int pick_id();
    case ($urandom_range(5))
      0: return 'h2A;
      1: return 'h10;
      2: return 'h3FF;
      3: return 'h05;
      4: return 'h155;
      default: return int'($urandom_range(1023));
    endcase
  endfunction

  initial begin
    int n;
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk); #1;
    chk_reset_outputs("reset");

    wr(3, 1, 'h2A, 'b0100);
    req(1, 'h2A); wait_done();
    req(0, 'h3FF); wait_done();

    req(4, 'h05); wait_done();
    resp_ready = 1'b0;
    req(0, 'h2A); req(2, 'h2A); req(4, 'h2A);
    n = 0;
    while (!resp_valid && n < 100) begin tick(); n++; end
    repeat (5) tick();
    resp_ready = 1'b1;
    wait_done();
    req(0, 'h2A); wait_done();

    wr(1, 1, 'h10, 'b0001); wr(7, 1, 'h10, 'b1000);
    req(2, 'h10); wait_done();
    wr(1, 0, 'h10, 'b0001);
    req(3, 'h10); wait_done();

    req(0, 'h3FF);
    repeat (3) tick();
    set_cfg(9, 1, 'h3FF, 'b0010);
    wait_done();
    req(1, 'h3FF); wait_done();
    set_cfg(2, 1, 'h3FF, 'b1000);
    req(2, 'h3FF); wait_done();

    req(0, 'h2A); wait_done();
    req(0, 'h2A); wait_done();
    wr(3, 1, 'h2A, 'b0100);
    req(0, 'h2A); wait_done();

    req(1, 'h123);
    repeat (6) tick();
    rst = 1'b1; req_valid = '0;
    tick();
    chk_reset_outputs("midscan_reset");
    rst = 1'b0;
    repeat (40) tick();
    req(0, 'h2A); wait_done();

    for (int t = 0; t < 3000; t++) begin
      for (int p = 0; p < NPORT; p++)
        if (!req_valid[p] && $urandom_range(3) == 0) req(p, pick_id());
      if (!cfg_we && $urandom_range(19) == 0)
        set_cfg(int'($urandom_range(DEPTH - 1)), $urandom_range(3) != 0, pick_id(),
                1 << $urandom_range(CN - 1));
      resp_ready = ($urandom_range(3) != 0);
      tick();
    end
    resp_ready = 1'b1;
    wait_done();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/gather_rt_lookup_arbiter.md
Name: gather_rt_lookup_arbiter

Overview:
Shares one programmable gather route table between NPORT input-port lookup requesters. Round-robin arbitration picks one requester at a time. A scan FSM searches the table one entry per cycle and returns the one-hot candidate output VC to the granted port. The block also owns the runtime write path used to program table entries. It sits between the router input units and VC allocation, and provides the multi-port, programmable form of the gather routing lookup.

Parameters:
NPORT, 5, number of requesting input ports
DEPTH, `ROUTE_TABLE_DEPTH (32), number of table entries
CN, `CN, candidate output VC vector width (one-hot)
IDW, 10, stream_id width

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
req_valid  in  NPORT  per-port lookup request
req_stream_id  in  NPORT*IDW  per-port stream_id, port p at [p*IDW +: IDW]
req_ready  out  NPORT  one-hot grant/accept pulse
resp_valid  out  1  lookup result valid
resp_port  out  $clog2(NPORT)  port index the result belongs to
resp_vc  out  CN  candidate output VC; single bit set on hit, all zero on miss
resp_miss  out  1  no matching valid entry
resp_ready  in  1  consumer accepts result
cfg_we  in  1  table write strobe
cfg_addr  in  $clog2(DEPTH)  entry index
cfg_entry_valid  in  1  entry valid bit
cfg_id  in  IDW  entry stream_id
cfg_vc  in  CN  entry candidate VC
cfg_ready  out  1  write accepted this cycle (high only in IDLE)

Behaviour:
- Interface timing: one clock; reset is synchronous and active-high.
- Reset: FSM to IDLE; all table valid bits cleared; RR pointer = 0; req_ready = 0; resp_valid = 0; resp_port = 0; resp_vc = 0; resp_miss = 0; cfg_ready = 1. Reset mid-scan or mid-response drops the pending lookup; no response is produced.
- Table: DEPTH x {valid, vc[CN], id[IDW]} registers. Write happens at the clock edge when cfg_we && cfg_ready.
- FSM IDLE: cfg_ready = 1.
  - If cfg_we is high, perform the write. No grant is issued that cycle; configuration has priority over lookups.
  - Otherwise, if any req_valid is set, grant the first requester at or after the RR pointer (wrapping at NPORT-1 to 0).
  - On grant: req_ready[g] pulses for 1 cycle, stream_id is latched, g is latched, the RR pointer becomes (g+1) mod NPORT, and the FSM goes to SCAN with idx = 0.
- FSM SCAN: cfg_ready = 0; cfg_we is ignored and the writer must hold the write.
  - Each cycle, compare entry[idx]. On valid && id == latched id: capture vc, clear miss, go to RESP.
  - If idx == DEPTH-1 with no match: vc = 0, miss = 1, go to RESP.
  - Otherwise idx++.
  - Lowest matching index wins.
- FSM RESP: resp_valid = 1. resp_port, resp_vc and resp_miss are stable until resp_valid && resp_ready; the FSM then returns to IDLE in the next cycle.
- Latency: grant edge to resp_valid is k+1 cycles for a hit at index k; a miss takes DEPTH cycles.
- Throughput: at most one lookup in flight. A requester must hold req_valid and its stream_id until its req_ready.
- req_ready is never asserted for a port whose req_valid is low. At most one req_ready bit is set per cycle.

Optional Feature:
Macro: GATHER_RT_LAST_HIT_CACHE_EN
- With the macro: a one-entry cache of {valid, id, vc} holds the most recent hit.
  - A grant whose stream_id matches the cache skips SCAN and enters RESP the next cycle (latency 1).
  - The cache is filled only on a hit, never on a miss.
  - Any accepted cfg write invalidates the cache. Reset invalidates it.
- Without the macro: no cache logic; every lookup scans.

Decomposition:
- Package gather_rt_pkg holds:
  - rt_entry_t struct {valid, vc[CN], id[IDW]}
  - fsm enum {IDLE, SCAN, RESP}
  - IDW and the default NPORT
- Sub-module rr_arbiter (NPORT-wide, pointer register, one-hot grant, advance-on-grant input) is instantiated once.
- Table storage and the scan FSM stay in the top module.

Test Plan:
- Reset, then write entry 3 = {1, id 0x2A, vc 4'b0100}; port 1 requests 0x2A -> req_ready = 5'b00010 for 1 cycle; resp_valid 4 cycles after the grant edge; resp_port = 1, resp_vc = 4'b0100, resp_miss = 0.
- Port 0 requests 0x3FF with no match -> resp after DEPTH = 32 cycles; resp_vc = 0, resp_miss = 1.
- Ports 0, 2 and 4 all hold requests with the pointer at 0 -> grant order 0, 2, 4, then 0 again. Hold resp_ready = 0 for 5 cycles on the first response -> outputs stable and no new grant.
- Duplicate id 0x10 in entries 1 (vc 0001) and 7 (vc 1000) -> resp_vc = 0001. Clear entry 1 (cfg_entry_valid = 0) -> resp_vc = 1000.
- cfg_we asserted during SCAN -> cfg_ready = 0, no table change until IDLE. cfg_we and req_valid together in IDLE -> write happens first, grant one cycle later.
- (GATHER_RT_LAST_HIT_CACHE_EN) Look up 0x2A twice -> second response 1 cycle after the grant. Rewrite entry 3, then look up again -> full scan latency (4 cycles).
- Assert rst during SCAN -> all outputs at reset values the next cycle; no response emitted.
